// File: rtl/neuron_core_scheduler.sv
// ----------------------------------------------------------------------------
// neuron_core_scheduler
//
// Sequencer for one timestep of the 256-neuron x 256-axon core. A start pulse
// latches the incoming axon spike vector and the per-axon weight types. The
// block then visits every neuron in order. For each neuron it addresses the
// synapse memory for one cycle, streams 256 axon slots into the neuron
// datapath, and records the spike that the datapath returns.
//
// Ports
//   clk                 core clock, rising edge
//   rst                 synchronous active-high reset
//   start_i             begin a timestep (only honoured while idle)
//   axon_spikes_i[255:0]  input spike per axon, latched on start
//   axon_types_i[511:0]   2-bit weight type per axon, latched on start
//   syn_addr_o[7:0]     synapse memory row address (current neuron)
//   syn_row_i[255:0]    connection bits of the addressed row (1-cycle read)
//   nb_enable_o         datapath axon slot valid
//   nb_first_o          first axon slot of a neuron
//   nb_last_o           last axon slot of a neuron
//   nb_weight_select_o  weight type 0..3, or 8'hFF for a zero weight
//   nb_neuron_o[7:0]    current neuron index for datapath parameter fetch
//   nb_spike_i          datapath spike result, valid the cycle after last slot
//   busy_o              high whenever a timestep is in progress
//   done_o              one-cycle pulse at the end of a timestep
//   spikes_o[255:0]     output spike vector, bit n = neuron n
// ----------------------------------------------------------------------------
module neuron_core_scheduler (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [255:0] axon_spikes_i,
   input  logic [511:0] axon_types_i,
   output logic [7:0]   syn_addr_o,
   input  logic [255:0] syn_row_i,
   output logic         nb_enable_o,
   output logic         nb_first_o,
   output logic         nb_last_o,
   output logic [7:0]   nb_weight_select_o,
   output logic [7:0]   nb_neuron_o,
   input  logic         nb_spike_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [255:0] spikes_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_INTEGRATE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   localparam logic [7:0] LAST_INDEX  = 8'd255;
   localparam logic [7:0] ZERO_WEIGHT = 8'hFF;

   state_t        state_q, state_d;
   logic [7:0]    n_q, n_d;
   logic [7:0]    a_q, a_d;
   logic [255:0]  spikes_q, spikes_d;
   logic [511:0]  types_q, types_d;
   logic [255:0]  spikes_out_q, spikes_out_d;

   logic          slot_active;
   logic [1:0]    slot_type;

   // State and datapath registers. Reset returns everything to the idle
   // picture, which also discards any partially collected spike results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         n_q          <= 8'd0;
         a_q          <= 8'd0;
         spikes_q     <= '0;
         types_q      <= '0;
         spikes_out_q <= '0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         a_q          <= a_d;
         spikes_q     <= spikes_d;
         types_q      <= types_d;
         spikes_out_q <= spikes_out_d;
      end
   end

   // Next-state logic. Each neuron costs FETCH + 256 INTEGRATE + CAPTURE,
   // i.e. 258 cycles. The neuron index only moves forward in CAPTURE and is
   // only rewound by a new start, so it still reads 255 after completion.
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      a_d          = a_q;
      spikes_d     = spikes_q;
      types_d      = types_q;
      spikes_out_d = spikes_out_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               spikes_d     = axon_spikes_i;
               types_d      = axon_types_i;
               n_d          = 8'd0;
               a_d          = 8'd0;
               spikes_out_d = '0;
               state_d      = ST_FETCH;
            end
         end

         ST_FETCH: begin
            // The synapse row appears one cycle after the address, so the
            // first axon slot lines up with the start of INTEGRATE.
            a_d     = 8'd0;
            state_d = ST_INTEGRATE;
         end

         ST_INTEGRATE: begin
            if (a_q == LAST_INDEX) begin
               state_d = ST_CAPTURE;
            end else begin
               a_d = a_q + 8'd1;
            end
         end

         ST_CAPTURE: begin
            spikes_out_d[n_q] = nb_spike_i;
            if (n_q == LAST_INDEX) begin
               state_d = ST_DONE;
            end else begin
               n_d     = n_q + 8'd1;
               state_d = ST_FETCH;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // An axon contributes only when it is both connected to this neuron and
   // spiking this timestep. Otherwise the datapath is told to add zero.
   assign slot_active = syn_row_i[a_q] & spikes_q[a_q];
   assign slot_type   = types_q[{a_q, 1'b0} +: 2];

   // Output decode. Every output comes from registered state; only the weight
   // select also looks at the synapse row, which is itself a registered read.
   always_comb begin
      nb_enable_o        = 1'b0;
      nb_first_o         = 1'b0;
      nb_last_o          = 1'b0;
      nb_weight_select_o = ZERO_WEIGHT;
      busy_o             = (state_q != ST_IDLE);
      done_o             = (state_q == ST_DONE);

      if (state_q == ST_INTEGRATE) begin
         nb_enable_o = 1'b1;
         nb_first_o  = (a_q == 8'd0);
         nb_last_o   = (a_q == LAST_INDEX);
         if (slot_active) begin
            nb_weight_select_o = {6'b0, slot_type};
         end
      end
   end

   assign syn_addr_o  = n_q;
   assign nb_neuron_o = n_q;
   assign spikes_o    = spikes_out_q;

endmodule

// File: tb/tb_neuron_core_scheduler.sv
// ----------------------------------------------------------------------------
// tb_neuron_core_scheduler
//
// Directed bench for neuron_core_scheduler. A behavioural synapse memory
// answers the row address one cycle later. Every cycle the whole visible
// output picture is compared against a cycle-indexed model that is written
// from the timestep schedule alone (FETCH at 1+258n, slot a at 2+258n+a,
// CAPTURE at 258+258n, DONE at 66049).
// ----------------------------------------------------------------------------
module tb_neuron_core_scheduler;

   logic         clk;
   logic         rst;
   logic         start_i;
   logic [255:0] axon_spikes_i;
   logic [511:0] axon_types_i;
   logic [7:0]   syn_addr_o;
   logic [255:0] syn_row_i;
   logic         nb_enable_o;
   logic         nb_first_o;
   logic         nb_last_o;
   logic [7:0]   nb_weight_select_o;
   logic [7:0]   nb_neuron_o;
   logic         nb_spike_i;
   logic         busy_o;
   logic         done_o;
   logic [255:0] spikes_o;

   int checks;
   int errors;
   int scen;

   neuron_core_scheduler dut (
      .clk                (clk),
      .rst                (rst),
      .start_i            (start_i),
      .axon_spikes_i      (axon_spikes_i),
      .axon_types_i       (axon_types_i),
      .syn_addr_o         (syn_addr_o),
      .syn_row_i          (syn_row_i),
      .nb_enable_o        (nb_enable_o),
      .nb_first_o         (nb_first_o),
      .nb_last_o          (nb_last_o),
      .nb_weight_select_o (nb_weight_select_o),
      .nb_neuron_o        (nb_neuron_o),
      .nb_spike_i         (nb_spike_i),
      .busy_o             (busy_o),
      .done_o             (done_o),
      .spikes_o           (spikes_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scenario 0 (masking): only axon 5 spikes, axon 5 type 3, all others
   // type 2; axon 5 connected only on even neurons, every other axon connected.
   // Scenario 1 (full): everything spikes, every type 01, full connectivity.
   function automatic logic rowBit(input int n, input int a, input int s);
      if (s == 0) return (a == 5) ? (n % 2 == 0) : 1'b1;
      return 1'b1;
   endfunction

   function automatic logic spikeBit(input int a, input int s);
      if (s == 0) return (a == 5);
      return 1'b1;
   endfunction

   function automatic logic [1:0] typeOf(input int a, input int s);
      if (s == 0) return (a == 5) ? 2'd3 : 2'd2;
      return 2'd1;
   endfunction

   function automatic logic [255:0] rowFor(input logic [7:0] addr, input int s);
      logic [255:0] r;
      r = '0;
      for (int a = 0; a < 256; a++) r[a] = rowBit(int'(addr), a, s);
      return r;
   endfunction

   // Synapse memory: synchronous read with one cycle of latency.
   always @(posedge clk) syn_row_i <= rowFor(syn_addr_o, scen);

   // Neurons whose datapath reports a spike in the full scenario.
   function automatic logic spikingNeuron(input int n, input int s);
      return (s == 1) && (n == 0 || n == 7 || n == 255);
   endfunction

   // Expected outputs during cycle r after the start was sampled (r = 0 means
   // idle with n = 0 and nothing captured). Packed as
   // {spikes, busy, done, enable, first, last, select, syn_addr, neuron}.
   function automatic logic [284:0] modelAt(input int r, input int s);
      logic [255:0] sp;
      logic         bz, dn, en, fi, la;
      logic [7:0]   sel, nn;
      int           k, p, a;
      sp = '0; bz = 1'b0; dn = 1'b0; en = 1'b0; fi = 1'b0; la = 1'b0;
      sel = 8'hFF; nn = 8'd0;
      for (int i = 0; i < 256; i++) begin
         if (spikingNeuron(i, s) && (258 + 258 * i) < r) sp[i] = 1'b1;
      end
      if (r >= 66050) begin
         nn = 8'd255;
      end else if (r == 66049) begin
         bz = 1'b1; dn = 1'b1; nn = 8'd255;
      end else if (r >= 1) begin
         bz = 1'b1;
         k  = r - 1;
         nn = 8'(k / 258);
         p  = k % 258;
         if (p >= 1 && p <= 256) begin
            a  = p - 1;
            en = 1'b1;
            fi = (a == 0);
            la = (a == 255);
            if (rowBit(int'(nn), a, s) && spikeBit(a, s)) sel = {6'b0, typeOf(a, s)};
         end
      end
      return {sp, bz, dn, en, fi, la, sel, nn, nn};
   endfunction

   task automatic applyStimulus(input logic start, input logic spike, input logic reset);
      start_i    = start;
      nb_spike_i = spike;
      rst        = reset;
   endtask

   task automatic checkOutput(input string tag, input int cyc, input logic [284:0] expected);
      logic [284:0] observed;
      observed = {spikes_o, busy_o, done_o, nb_enable_o, nb_first_o, nb_last_o,
                  nb_weight_select_o, syn_addr_o, nb_neuron_o};
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      scen          = 0;
      axon_spikes_i = '0;
      axon_types_i  = '0;
      applyStimulus(1'b1, 1'b0, 1'b1);

      // Reset held for two cycles with start asserted: reset must win.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("resetHold", c, modelAt(0, 0));
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("idleAfterReset", c, modelAt(0, 0));
      end

      // Masking scenario, aborted by a reset at cycle 1000.
      $display("[TB] masking run with reset at cycle 1000");
      scen          = 0;
      axon_spikes_i = '0;
      axon_spikes_i[5] = 1'b1;
      for (int i = 0; i < 256; i++) axon_types_i[2*i +: 2] = typeOf(i, 0);
      for (int c = 0; c <= 1005; c++) begin
         if (c <= 1000) checkOutput("maskRun", c, modelAt(c, 0));
         else           checkOutput("midRunReset", c, modelAt(0, 0));
         applyStimulus(c == 0, 1'b0, c == 1000);
         @(negedge clk);
      end

      // Full timestep with spike capture, ignored starts and an immediate
      // restart at the earliest legal cycle.
      $display("[TB] full run with captures on neurons 0, 7 and 255");
      scen          = 1;
      axon_spikes_i = '1;
      for (int i = 0; i < 256; i++) axon_types_i[2*i +: 2] = typeOf(i, 1);
      for (int c = 0; c <= 66060; c++) begin
         if (c <= 66050) checkOutput("fullRun", c, modelAt(c, 1));
         else            checkOutput("restart", c, modelAt(c - 66050, 1));
         applyStimulus(c == 0 || c == 500 || c == 66049 || c == 66050,
                       c == 258 || c == 258 + 258 * 7 || c == 258 + 258 * 255,
                       1'b0);
         @(negedge clk);
      end

      // Reset during the second timestep clears everything again.
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("finalReset", 0, modelAt(0, 1));
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("finalIdle", 1, modelAt(0, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_core_scheduler.md
# neuron_core_scheduler

Sequencer for the 256x256 neuron core. One `start_i` pulse processes one timestep. The block latches the input axon spike vector and the axon weight types. It then walks all 256 neurons. For each neuron it fetches that neuron's synapse row, streams 256 axon slots into the neuron datapath, and captures the neuron's spike into an output vector. It sits between the core's host/router interface, the synapse connection memory and the neuron block datapath.

## Interface
- No parameters; the 256 neurons x 256 axons geometry is fixed.
- `clk` in 1: core clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a timestep; sampled only in IDLE.
- `axon_spikes_i` in 256: input spike per axon; latched on start.
- `axon_types_i` in 512: 2-bit weight type per axon; axon a uses bits [2a+1:2a]; latched on start.
- `syn_addr_o` out 8: synapse memory row address (neuron index).
- `syn_row_i` in 256: connection bits for the row at `syn_addr_o`.
  - Synchronous read, 1-cycle latency.
  - Stays stable while the address is held.
- `nb_enable_o` out 1: datapath axon slot valid.
- `nb_first_o` out 1: high on axon 0 slot.
- `nb_last_o` out 1: high on axon 255 slot.
- `nb_weight_select_o` out 8: 0..3 selects weight type 1..4; 8'hFF selects zero weight.
- `nb_neuron_o` out 8: current neuron index (parameter fetch for the datapath).
- `nb_spike_i` in 1: datapath spike result; valid in the cycle after `nb_last_o`.
- `busy_o` out 1: high in every non-IDLE state.
- `done_o` out 1: one-cycle pulse when the timestep completes.
- `spikes_o` out 256: output spike vector.
  - Bit n holds neuron n's result.
  - Cleared on start.

## Operation
- States: IDLE, FETCH, INTEGRATE, CAPTURE, DONE.
- IDLE: `start_i`=1 at the edge causes the following:
  - latch `axon_spikes_i` into spikes_q and `axon_types_i` into types_q;
  - set n=0 and clear `spikes_o`;
  - go to FETCH.
- `start_i` outside IDLE is ignored; it is neither queued nor a restart.
- FETCH (1 cycle): `syn_addr_o`=n. Go to INTEGRATE with a=0.
- INTEGRATE (256 cycles, a=0..255):
  - `nb_enable_o`=1;
  - `nb_first_o`=(a==0) and `nb_last_o`=(a==255);
  - if syn_row_i[a] & spikes_q[a], then `nb_weight_select_o`={6'b0, types_q[2a+1:2a]};
  - otherwise `nb_weight_select_o`=8'hFF.
  - `syn_row_i` is used directly; `syn_addr_o` holds n.
  - When a reaches 255, go to CAPTURE.
- CAPTURE (1 cycle): at the edge, spikes_o[n] <= `nb_spike_i`.
  - If n==255, go to DONE.
  - Otherwise n <= n+1 and go to FETCH.
- DONE (1 cycle): `done_o`=1. Go to IDLE.
- Counters:
  - n and a are 8-bit.
  - The terminal tests are n==255 and a==255; no counter wraps past 255 during operation.
  - n returns to 0 only on start or reset.
- Outside INTEGRATE:
  - `nb_enable_o`, `nb_first_o` and `nb_last_o` are 0;
  - `nb_weight_select_o`=8'hFF.
- `nb_neuron_o`=n and `syn_addr_o`=n in all states.
- `spikes_o` holds its value after DONE until the next start or reset.

## Timing
- Reset values:
  - state IDLE, n=0, a=0;
  - `syn_addr_o`=0, `nb_neuron_o`=0;
  - `nb_enable_o`=0, `nb_first_o`=0, `nb_last_o`=0;
  - `nb_weight_select_o`=8'hFF;
  - `busy_o`=0, `done_o`=0;
  - `spikes_o`=0, spikes_q=0, types_q=0.
- All outputs are registered or decoded from state only. Start-to-output latency is 1 cycle.
- Cycle 0 is the cycle in which `start_i` is sampled. Relative to it:
  - neuron n FETCH is at cycle 1+258n;
  - neuron n axon a slot is at cycle 2+258n+a;
  - neuron n CAPTURE is at cycle 258+258n.
- Completion:
  - `done_o` is high at cycle 66049;
  - `busy_o` is high from cycle 1 through cycle 66049;
  - IDLE is reached at cycle 66050;
  - a new start is accepted at the earliest at cycle 66050.
- Each neuron takes 258 cycles.
- `rst` mid-operation: on the next edge, return to IDLE with all reset values.
  - No `done_o` is generated.
  - Partial `spikes_o` results are discarded.
- `rst` and `start_i` high together: `rst` wins.

## Test plan
- Reset:
  - Stimulus: hold `rst` 2 cycles with `start_i`=1.
  - Response: all outputs at reset values, `busy_o`=0, no FETCH afterwards.
- Full timestep:
  - Stimulus: all spikes=1, all types=2'b01, `syn_row_i`=all 1s.
  - Response: `nb_weight_select_o`=1 on every slot; `nb_first_o`/`nb_last_o` at cycles 2 and 257 for neuron 0; `done_o` exactly at cycle 66049.
- Masking:
  - Stimulus: spikes=only axon 5; `syn_row_i` bit 5=1 for even neurons and 0 for odd; types[5]=3.
  - Response: select=3 only at slot a=5 of even neurons; 8'hFF everywhere else.
- Spike capture:
  - Stimulus: `nb_spike_i`=1 in CAPTURE only for neurons 0, 7 and 255.
  - Response: `spikes_o` at done has exactly bits 0, 7 and 255 set; `spikes_o` is cleared on the next start.
- Start ignored:
  - Stimulus: pulse `start_i` at cycle 500 and cycle 66049.
  - Response: timing unchanged, a single `done_o`; a start at cycle 66050 begins a new timestep with FETCH at cycle 66051.
- Reset mid-run:
  - Stimulus: `rst` at cycle 1000.
  - Response: IDLE next cycle, `spikes_o`=0, no `done_o`; a subsequent start runs the full 66049-cycle sequence.
